// File: rtl/instr_mem_prog_if.sv
// Fetch and program port bundle for the runtime-loadable instruction memory.
// The master drives requests and writes; the slave is the memory itself.
interface instr_mem_prog_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32,
   parameter int unsigned PA_W = 7
);
   logic            fetch_req;
   logic [PC_W-1:0] fetch_addr;
   logic            fetch_stall;
   logic            fetch_ready;
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_instr;
   logic            fetch_fault;
   logic            prog_we;
   logic [PA_W-1:0] prog_addr;
   logic [XLEN-1:0] prog_data;
   logic            prog_busy;
   logic            prog_err;
   logic            init_done;

   modport master (
      output fetch_req, fetch_addr, fetch_stall, prog_we, prog_addr, prog_data,
      input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_busy, prog_err, init_done
   );

   modport slave (
      input  fetch_req, fetch_addr, fetch_stall, prog_we, prog_addr, prog_data,
      output fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_busy, prog_err, init_done
   );
endinterface

// File: rtl/instr_mem_prog.sv
// Runtime-loadable instruction memory: boot clear to FILL, word-wise program port,
// registered fetch port with ready/valid/stall and misaligned/out-of-range fault flagging.
module instr_mem_prog #(
   parameter int unsigned     XLEN  = 32,
   parameter int unsigned     DEPTH = 128,
   parameter int unsigned     PC_W  = 32,
   parameter int unsigned     PA_W  = 7,
   parameter logic [XLEN-1:0] FILL  = XLEN'(32'h00000013)
) (
   input logic             clk,
   input logic             rst,
   instr_mem_prog_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit on each bound so DEPTH itself is representable when DEPTH == 2**width.
   localparam logic [PC_W-2:0] DEPTH_PC = (PC_W-1)'(DEPTH);
   localparam logic [PA_W:0]   DEPTH_PA = (PA_W+1)'(DEPTH);
   localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);

   typedef enum logic {StClear, StReady} state_e;

   state_e          state_q;
   logic [AW-1:0]   clr_ptr_q;
   logic            valid_q;
   logic [XLEN-1:0] instr_q;
   logic            fault_q;
   logic            err_q;
   logic            done_q;
   logic [XLEN-1:0] mem [DEPTH];

   logic [PC_W-3:0] fetch_word;
   logic            fault_d;
   logic            prog_ok;
   logic            in_ready;
   logic            hold;
   logic            ready;
   logic            accept;
   logic            prog_wr;
   logic            wr_hit;
   logic [XLEN-1:0] rd_data;

   always_comb begin
      fetch_word = bus.fetch_addr[PC_W-1:2];
      fault_d    = (bus.fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_word} >= DEPTH_PC);
      prog_ok    = {1'b0, bus.prog_addr} < DEPTH_PA;
      in_ready   = (state_q == StReady);
      hold       = valid_q && bus.fetch_stall;
      ready      = in_ready && !hold;
      accept     = bus.fetch_req && ready;
      prog_wr    = in_ready && bus.prog_we && prog_ok;
      // Write-first bypass: both indices are in range here, so low-bit equality is exact.
      wr_hit     = prog_wr && (bus.prog_addr[AW-1:0] == fetch_word[AW-1:0]);
      rd_data    = wr_hit ? bus.prog_data : mem[fetch_word[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         mem[clr_ptr_q] <= FILL;
      end else if (prog_wr) begin
         mem[bus.prog_addr[AW-1:0]] <= bus.prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
         valid_q   <= 1'b0;
         instr_q   <= FILL;
         fault_q   <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            StClear: begin
               clr_ptr_q <= clr_ptr_q + AW'(1);
               if (clr_ptr_q == LAST) begin
                  state_q <= StReady;
                  done_q  <= 1'b1;
               end
            end
            StReady: begin
               err_q <= bus.prog_we && !prog_ok;
               if (accept) begin
                  valid_q <= 1'b1;
                  fault_q <= fault_d;
                  instr_q <= fault_d ? FILL : rd_data;
               end else if (!hold) begin
                  valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.fetch_ready = ready;
   assign bus.fetch_valid = valid_q;
   assign bus.fetch_instr = instr_q;
   assign bus.fetch_fault = fault_q;
   assign bus.prog_busy   = (state_q == StClear);
   assign bus.prog_err    = err_q;
   assign bus.init_done   = done_q;
endmodule

// File: tb/tb_instr_mem_prog.sv
// Self-checking bench for instr_mem_prog: directed scenarios plus a randomized run
// against a word-array reference model of the memory and fetch port.
module tb_instr_mem_prog;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 128;
   localparam int unsigned PC_W  = 32;
   localparam int unsigned PA_W  = 8;
   localparam logic [31:0] FILL  = 32'h00000013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [31:0] model [DEPTH];

   instr_mem_prog_if #(.XLEN(XLEN), .PC_W(PC_W), .PA_W(PA_W)) bus ();

   instr_mem_prog #(
      .XLEN(XLEN), .DEPTH(DEPTH), .PC_W(PC_W), .PA_W(PA_W), .FILL(FILL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = FILL;
   endtask

   function automatic logic exp_fault(logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
   endfunction

   function automatic logic [31:0] exp_instr(logic [31:0] a);
      if (exp_fault(a)) return FILL;
      return model[int'(a[31:2])];
   endfunction

   task automatic idle_inputs();
      bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_stall = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
   endtask

   task automatic prog_write(input int a, input logic [31:0] d);
      bus.prog_we = 1'b1; bus.prog_addr = PA_W'(a); bus.prog_data = d;
      tick();
      bus.prog_we = 1'b0;
      if (a < DEPTH) model[a] = d;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== FILL || bus.fetch_fault !== 1'b0 ||
          bus.prog_err !== 1'b0 || bus.init_done !== 1'b0 || bus.prog_busy !== 1'b1 ||
          bus.fetch_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b i=%h f=%b e=%b d=%b b=%b r=%b want 0 %h 0 0 0 1 0",
                  bus.fetch_valid, bus.fetch_instr, bus.fetch_fault, bus.prog_err,
                  bus.init_done, bus.prog_busy, bus.fetch_ready, FILL);
      end
   endtask

   task automatic test_boot_clear();
      rst = 1'b1;
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
      model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (bus.fetch_ready !== 1'b0 || bus.prog_busy !== 1'b1 || bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_busy cycle %0d: got r=%b b=%b d=%b want 0 1 0", i,
                     bus.fetch_ready, bus.prog_busy, bus.init_done);
         end
         tick();
      end
      n_cmp++;
      if (bus.init_done !== 1'b1 || bus.prog_busy !== 1'b0 || bus.fetch_ready !== 1'b1 ||
          bus.fetch_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_done: got d=%b b=%b r=%b v=%b want 1 0 1 0", bus.init_done,
                  bus.prog_busy, bus.fetch_ready, bus.fetch_valid);
      end
      tick();
      bus.fetch_req = 1'b0;
      n_cmp++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== FILL || bus.fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_first_fetch: got v=%b i=%h f=%b want 1 %h 0", bus.fetch_valid,
                  bus.fetch_instr, bus.fetch_fault, FILL);
      end
      tick();
   endtask

   task automatic test_load_stream();
      logic [31:0] addrs [2];
      addrs[0] = 32'h4; addrs[1] = 32'h8;
      prog_write(1, 32'h019806B3);
      prog_write(2, 32'h403402B3);
      bus.fetch_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.fetch_addr = addrs[k];
         tick();
         n_cmp++;
         if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== exp_instr(addrs[k]) ||
             bus.fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%b i=%h f=%b want 1 %h 0", k, bus.fetch_valid,
                     bus.fetch_instr, bus.fetch_fault, exp_instr(addrs[k]));
         end
      end
      bus.fetch_req = 1'b0;
      tick();
      n_cmp++;
      if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== 32'h403402B3) begin
         n_fail++;
         $display("FAIL stream_idle: got v=%b i=%h want 0 403402b3", bus.fetch_valid,
                  bus.fetch_instr);
      end
   endtask

   task automatic test_faults();
      logic [31:0] addrs [5];
      addrs[0] = 32'h1FC; addrs[1] = 32'h6; addrs[2] = 32'h200;
      addrs[3] = 32'hFFFFFFFC; addrs[4] = 32'h120;
      prog_write(127, 32'hA5A50127);
      n_cmp++;
      if (bus.prog_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_on_valid_write: got %b want 0", bus.prog_err);
      end
      prog_write(72, 32'h12345672);
      prog_write(200, 32'h0BADF00D);
      n_cmp++;
      if (bus.prog_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_pulse: got %b want 1", bus.prog_err);
      end
      tick();
      n_cmp++;
      if (bus.prog_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_one_cycle: got %b want 0", bus.prog_err);
      end
      for (int k = 0; k < 5; k++) begin
         bus.fetch_req = 1'b1; bus.fetch_addr = addrs[k];
         tick();
         n_cmp++;
         if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== exp_instr(addrs[k]) ||
             bus.fetch_fault !== exp_fault(addrs[k])) begin
            n_fail++;
            $display("FAIL fault_addr %h: got v=%b i=%h f=%b want 1 %h %b", addrs[k],
                     bus.fetch_valid, bus.fetch_instr, bus.fetch_fault, exp_instr(addrs[k]),
                     exp_fault(addrs[k]));
         end
      end
      bus.fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
      tick();
      bus.fetch_stall = 1'b1; bus.fetch_addr = 32'h8;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (bus.fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready %0d: got %b want 0", k, bus.fetch_ready);
         end
         tick();
         n_cmp++;
         if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== model[1]) begin
            n_fail++;
            $display("FAIL stall_hold %0d: got v=%b i=%h want 1 %h", k, bus.fetch_valid,
                     bus.fetch_instr, model[1]);
         end
      end
      bus.fetch_stall = 1'b0;
      #1;
      n_cmp++;
      if (bus.fetch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release_ready: got %b want 1", bus.fetch_ready);
      end
      tick();
      bus.fetch_req = 1'b0;
      n_cmp++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== model[2]) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b i=%h want 1 %h", bus.fetch_valid,
                  bus.fetch_instr, model[2]);
      end
      tick();
   endtask

   task automatic test_write_first();
      bus.prog_we = 1'b1; bus.prog_addr = 8'd5; bus.prog_data = 32'hDEADBEEF;
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h14;
      tick();
      bus.prog_we = 1'b0;
      model[5] = 32'hDEADBEEF;
      n_cmp++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_first: got v=%b i=%h want 1 deadbeef", bus.fetch_valid,
                  bus.fetch_instr);
      end
      bus.fetch_addr = 32'h0;
      tick();
      bus.fetch_addr = 32'h14;
      tick();
      bus.fetch_req = 1'b0;
      n_cmp++;
      if (bus.fetch_instr !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_first_stored: got %h want deadbeef", bus.fetch_instr);
      end
      tick();
   endtask

   task automatic test_random();
      logic        e_valid = 1'b0;
      logic        e_fault = 1'b0;
      logic        e_err = 1'b0;
      logic        known = 1'b0;
      logic [31:0] e_instr = '0;
      logic [31:0] a;
      int          pa;
      int          kind;
      for (int c = 0; c < 400; c++) begin
         n_cmp++;
         if (bus.fetch_valid !== e_valid || bus.prog_err !== e_err ||
             (known && (bus.fetch_instr !== e_instr || bus.fetch_fault !== e_fault))) begin
            n_fail++;
            $display("FAIL random cycle %0d: got v=%b i=%h f=%b e=%b want %b %h %b %b", c,
                     bus.fetch_valid, bus.fetch_instr, bus.fetch_fault, bus.prog_err,
                     e_valid, e_instr, e_fault, e_err);
         end
         kind = int'($urandom_range(0, 9));
         if (kind < 7)       a = {$urandom_range(0, DEPTH - 1), 2'b00};
         else if (kind == 7) a = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(1, 3))};
         else if (kind == 8) a = {$urandom_range(DEPTH, 400), 2'b00};
         else                a = $urandom;
         pa = int'($urandom_range(0, 255));
         bus.fetch_req   = ($urandom_range(0, 3) != 0);
         bus.fetch_addr  = a;
         bus.fetch_stall = ($urandom_range(0, 3) == 0);
         bus.prog_we     = ($urandom_range(0, 2) == 0);
         bus.prog_addr   = PA_W'(pa);
         bus.prog_data   = $urandom;
         #1;
         n_cmp++;
         if (bus.fetch_ready !== !(e_valid && bus.fetch_stall)) begin
            n_fail++;
            $display("FAIL random_ready cycle %0d: got %b want %b", c, bus.fetch_ready,
                     !(e_valid && bus.fetch_stall));
         end
         e_err = bus.prog_we && (pa >= DEPTH);
         if (bus.prog_we && pa < DEPTH) model[pa] = bus.prog_data;
         if (bus.fetch_req && !(e_valid && bus.fetch_stall)) begin
            e_valid = 1'b1; known = 1'b1;
            e_fault = exp_fault(a);
            e_instr = exp_instr(a);
         end else if (!(e_valid && bus.fetch_stall)) begin
            e_valid = 1'b0;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_mid_clear_reset();
      prog_write(3, 32'h33333333);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (60) tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.init_done !== 1'b0 || bus.prog_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midclear_reset: got d=%b b=%b want 0 1", bus.init_done, bus.prog_busy);
      end
      tick();
      rst = 1'b1;
      model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_done_early cycle %0d: got %b want 0", i, bus.init_done);
         end
         tick();
      end
      n_cmp++;
      if (bus.init_done !== 1'b1) begin
         n_fail++;
         $display("FAIL midclear_done: got %b want 1", bus.init_done);
      end
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'hC;
      tick();
      bus.fetch_req = 1'b0;
      n_cmp++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== exp_instr(32'hC)) begin
         n_fail++;
         $display("FAIL midclear_recleared: got v=%b i=%h want 1 %h", bus.fetch_valid,
                  bus.fetch_instr, exp_instr(32'hC));
      end
   endtask

   initial begin
      idle_inputs();
      model_clear();
      repeat (3) tick();
      test_reset();
      test_boot_clear();
      test_load_stream();
      test_faults();
      test_stall();
      test_write_first();
      test_random();
      test_mid_clear_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_mem_prog.md
Name: instr_mem_prog

Overview:
Parametrised, runtime-loadable instruction memory for the RISC-V core; the successor to the fixed-program, reset-loaded instruction ROM.
- After reset, a boot state machine fills every word with a NOP.
- A program port loads code word by word.
- A registered fetch port with a ready/valid/stall handshake feeds the IF stage.
- The fetch port flags misaligned and out-of-range PCs instead of aliasing them.

Parameters:
XLEN, 32, instruction/data word width in bits
DEPTH, 128, number of instruction words (>=2, need not be a power of two)
PC_W, 32, fetch byte-address width
PA_W, 7, program-port word-index width (>= clog2(DEPTH))
FILL, 32'h00000013, word written by boot clear and returned on faults (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch request
fetch_addr  in  PC_W  byte address (PC)
fetch_stall  in  1  consumer not accepting; hold current output
fetch_ready  out  1  request accepted this cycle when fetch_req=1
fetch_valid  out  1  fetch_instr/fetch_fault valid
fetch_instr  out  XLEN  fetched instruction
fetch_fault  out  1  misaligned or out-of-range fetch
prog_we  in  1  program-port write strobe
prog_addr  in  PA_W  word index
prog_data  in  XLEN  word to write
prog_busy  out  1  high while the memory is in the CLEAR state
prog_err  out  1  one-cycle pulse: write dropped (out of range)
init_done  out  1  boot clear complete

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=CLEAR, clr_ptr=0
  - fetch_valid=0, fetch_instr=FILL, fetch_fault=0
  - prog_err=0, init_done=0
  - Reset is honoured in any state, including mid-CLEAR; the clear restarts from word 0.
- CLEAR state:
  - Each cycle writes FILL to mem[clr_ptr], then clr_ptr+1.
  - Leaves CLEAR on the edge that writes word DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  - init_done=1 and prog_busy=0 from the next cycle onward.
  - In CLEAR: prog_busy=1, fetch_ready=0; prog_we is ignored (no prog_err).
- READY state: persists until reset.
- fetch_ready = (state==READY) && !(fetch_valid && fetch_stall). Combinational; no dependence on fetch_req.
- Accept = fetch_req && fetch_ready. On an accept edge, from the next cycle:
  - fetch_valid=1.
  - word = fetch_addr[PC_W-1:2].
  - fault = (fetch_addr[1:0]!=0) || (word >= DEPTH).
  - fetch_fault=fault; fetch_instr = fault ? FILL : mem[word].
  - Read latency is 1 cycle; back-to-back accepts give one result per cycle.
- Hold: if fetch_valid && fetch_stall, fetch_valid, fetch_instr and fetch_fault hold unchanged and no new request is accepted.
- If there is no accept and no stall, fetch_valid goes to 0 next cycle; fetch_instr and fetch_fault hold their last value.
- Program write in READY:
  - If prog_we && prog_addr<DEPTH, mem[prog_addr]=prog_data on the edge.
  - If prog_addr>=DEPTH, the write is dropped and prog_err=1 for exactly the next cycle.
- Same-cycle write and accept to the same word: write-first; fetch_instr returns the new prog_data.
- Simultaneous write and stall are independent; the write completes and the held output is not updated.
- Memory contents are not preserved across reset; every reset re-clears all words to FILL.
- Arithmetic:
  - The word >= DEPTH comparison is done at full PC_W-2 width, so there is no truncation aliasing.
  - prog_addr is compared at PA_W width.

Test Plan:
- Boot clear: release rst, DEPTH=128, fetch_req=1 at addr 0 → fetch_ready=0 and prog_busy=1 for 128 cycles; init_done rises on cycle 129; the first accepted fetch of addr 0x0 returns 0x00000013 with fault=0.
- Load and stream: write 0x01980 6B3 (add x13,x16,x25) to word 1 and 0x40340 2B3 to word 2, then fetch 0x4, 0x8 back-to-back → valid on consecutive cycles with those words, fault=0.
- Faults: fetch 0x6 → fault=1, instr=0x00000013; fetch 0x200 (word 128) → fault=1; prog_addr=127 write succeeds, a PA_W=8 build writing 200 → prog_err pulses exactly one cycle and memory is unchanged.
- Stall: hold fetch_stall=1 for 3 cycles after a valid result → fetch_ready=0, fetch_instr stable, a pending new fetch_req is not accepted until the cycle stall drops.
- Write-first: same edge prog_we to word 5 with 0xDEADBEEF and accept of fetch 0x14 → fetch_instr=0xDEADBEEF.
- Mid-clear reset: assert rst at clr_ptr=60, release → init_done only after a full 128 more cycles; a word written before reset reads 0x00000013.
